// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register: registers decoded operands and control, inserts load-use bubbles,
// honours EX back-pressure and branch flushes, and counts inserted bubbles (saturating).
module id_ex_stage_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic [9:0]       id_ctrl_i,
    input  logic             ex_stall_i,
    input  logic             flush_i,
    output logic             ex_valid_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [4:0]       ex_rs1_addr_o,
    output logic [4:0]       ex_rs2_addr_o,
    output logic [4:0]       ex_rd_addr_o,
    output logic [9:0]       ex_ctrl_o,
    output logic             id_stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    // ctrl layout {alu_op[3:0], alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}
    localparam int unsigned CTRL_MEM_READ = 3;

    logic             ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q,       ex_pc_d;
    logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
    logic [XLEN-1:0]  ex_imm_q,      ex_imm_d;
    logic [4:0]       ex_rs1_addr_q, ex_rs1_addr_d;
    logic [4:0]       ex_rs2_addr_q, ex_rs2_addr_d;
    logic [4:0]       ex_rd_addr_q,  ex_rd_addr_d;
    logic [9:0]       ex_ctrl_q,     ex_ctrl_d;
    logic [CNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;
    logic             lu_haz;

    always_comb begin
        lu_haz = ex_valid_q & ex_ctrl_q[CTRL_MEM_READ] & (ex_rd_addr_q != 5'd0) & id_valid_i &
                 ((id_use_rs1_i & (id_rs1_addr_i == ex_rd_addr_q)) |
                  (id_use_rs2_i & (id_rs2_addr_i == ex_rd_addr_q)));
        // Gated by reset so the stall request stays low while the core is held in reset.
        id_stall_o = rst_ni & ~flush_i & (ex_stall_i | lu_haz);
    end

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_rs1_addr_d = ex_rs1_addr_q;
        ex_rs2_addr_d = ex_rs2_addr_q;
        ex_rd_addr_d  = ex_rd_addr_q;
        ex_ctrl_d     = ex_ctrl_q;
        bubble_cnt_d  = bubble_cnt_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (ex_stall_i) begin
            // hold everything
        end else if (lu_haz) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d    = id_valid_i;
            ex_pc_d       = id_pc_i;
            ex_rs1_data_d = id_rs1_data_i;
            ex_rs2_data_d = id_rs2_data_i;
            ex_imm_d      = id_imm_i;
            ex_rs1_addr_d = id_rs1_addr_i;
            ex_rs2_addr_d = id_rs2_addr_i;
            ex_rd_addr_d  = id_rd_addr_i;
            ex_ctrl_d     = id_valid_i ? id_ctrl_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_addr_q <= '0;
            ex_rs2_addr_q <= '0;
            ex_rd_addr_q  <= '0;
            ex_ctrl_q     <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_addr_q <= ex_rs1_addr_d;
            ex_rs2_addr_q <= ex_rs2_addr_d;
            ex_rd_addr_q  <= ex_rd_addr_d;
            ex_ctrl_q     <= ex_ctrl_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_pc_o       = ex_pc_q;
    assign ex_rs1_data_o = ex_rs1_data_q;
    assign ex_rs2_data_o = ex_rs2_data_q;
    assign ex_imm_o      = ex_imm_q;
    assign ex_rs1_addr_o = ex_rs1_addr_q;
    assign ex_rs2_addr_o = ex_rs2_addr_q;
    assign ex_rd_addr_o  = ex_rd_addr_q;
    assign ex_ctrl_o     = ex_ctrl_q;
    assign bubble_cnt_o  = bubble_cnt_q;

endmodule
